csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_pkg.sv | 38 +++
 rtl/csr_unit_if.sv | 28 ++
 rtl/intr_sync.sv | 41 ++++
 rtl/csr_unit.sv | 124 ++++++++++++
 tb/tb_csr_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared CSR constants, operation encoding and the read-modify-write helper
// used by csr_unit.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    function automatic logic [31:0] csr_new_value(input logic [1:0] op,
                                                  input logic [31:0] old_val,
                                                  input logic [31:0] wd);
        logic [31:0] result;
        case (csr_op_e'(op))
            CSR_OP_RW: result = wd;
            CSR_OP_RS: result = old_val | wd;
            CSR_OP_RC: result = old_val & ~wd;
            default:   result = old_val;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/csr_unit_if.sv
// Bus between the control FSM / datapath and csr_unit; the control side
// uses the master modport, csr_unit the slave modport.
interface csr_unit_if;
    logic [11:0] CSR_ADDR;
    logic [1:0]  CSR_OP;
    logic        CSR_WE;
    logic [31:0] CSR_WD;
    logic [31:0] CSR_RD;
    logic [31:0] PC;
    logic        TAKE_INTR;
    logic        DO_MRET;
    logic        INTR_IN;
    logic        INTR;
    logic        MIE;
    logic        MTVEC_READY;
    logic [31:0] MTVEC;
    logic [31:0] MEPC;

    modport master (
        output CSR_ADDR, CSR_OP, CSR_WE, CSR_WD, PC, TAKE_INTR, DO_MRET, INTR_IN,
        input  CSR_RD, INTR, MIE, MTVEC_READY, MTVEC, MEPC
    );

    modport slave (
        input  CSR_ADDR, CSR_OP, CSR_WE, CSR_WD, PC, TAKE_INTR, DO_MRET, INTR_IN,
        output CSR_RD, INTR, MIE, MTVEC_READY, MTVEC, MEPC
    );
endinterface

// File: rtl/intr_sync.sv
// Two-flop synchronizer for the external interrupt, rising-edge detect
// against a third flop, and the sticky pending latch.
module intr_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_intr_async,
    input  logic i_clear,
    output logic o_pending
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic r_pending;
    logic w_rise;

    assign w_rise    = r_sync2 & ~r_sync3;
    assign o_pending = r_pending;

    // Synchronizer chain and pending latch; a new edge beats a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync3   <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_sync1 <= i_intr_async;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (w_rise) begin
                r_pending <= 1'b1;
            end else if (i_clear) begin
                r_pending <= 1'b0;
            end else begin
                r_pending <= r_pending;
            end
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file (mstatus, mtvec, mepc, mcause) with interrupt entry/return.
// Optional 64-bit mcycle counter when CSR_MCYCLE_EN is defined.
module csr_unit
    import csr_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    csr_unit_if.slave  bus
);

    logic        r_mie;
    logic        r_mpie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic        r_mtvec_ready;
    logic        w_pending;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic        w_commit;
    logic        w_wr_mstatus;
    logic        w_wr_mtvec;
    logic        w_wr_mepc;
    logic        w_wr_mcause;
`ifdef CSR_MCYCLE_EN
    logic [63:0] r_mcycle;
`endif

    intr_sync u_intr_sync (
        .i_clk        (CLK),
        .i_rst_n      (RESET_N),
        .i_intr_async (bus.INTR_IN),
        .i_clear      (bus.TAKE_INTR),
        .o_pending    (w_pending)
    );

    // Read mux: old value of the addressed CSR, zero for anything unimplemented.
    always_comb begin
        w_old = 32'h0000_0000;
        case (bus.CSR_ADDR)
            CSR_MSTATUS: begin
                w_old[MSTATUS_MIE_BIT]  = r_mie;
                w_old[MSTATUS_MPIE_BIT] = r_mpie;
            end
            CSR_MTVEC:   w_old = r_mtvec;
            CSR_MEPC:    w_old = r_mepc;
            CSR_MCAUSE:  w_old = r_mcause;
`ifdef CSR_MCYCLE_EN
            CSR_MCYCLE:  w_old = r_mcycle[31:0];
            CSR_MCYCLEH: w_old = r_mcycle[63:32];
`endif
            default:     w_old = 32'h0000_0000;
        endcase
    end

    assign w_new        = csr_new_value(bus.CSR_OP, w_old, bus.CSR_WD);
    assign w_commit     = bus.CSR_WE && (bus.CSR_OP != CSR_OP_NONE);
    assign w_wr_mstatus = w_commit && (bus.CSR_ADDR == CSR_MSTATUS);
    assign w_wr_mtvec   = w_commit && (bus.CSR_ADDR == CSR_MTVEC);
    assign w_wr_mepc    = w_commit && (bus.CSR_ADDR == CSR_MEPC);
    assign w_wr_mcause  = w_commit && (bus.CSR_ADDR == CSR_MCAUSE);

    // CSR state: trap entry overrides mret and software writes, except mtvec.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_mie         <= 1'b0;
            r_mpie        <= 1'b0;
            r_mtvec       <= 32'h0000_0000;
            r_mepc        <= 32'h0000_0000;
            r_mcause      <= 32'h0000_0000;
            r_mtvec_ready <= 1'b0;
        end else begin
            if (bus.TAKE_INTR) begin
                r_mepc   <= bus.PC & ALIGN_MASK;
                r_mcause <= MCAUSE_MEI;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else begin
                if (bus.DO_MRET) begin
                    r_mie  <= r_mpie;
                    r_mpie <= 1'b1;
                end else if (w_wr_mstatus) begin
                    r_mie  <= w_new[MSTATUS_MIE_BIT];
                    r_mpie <= w_new[MSTATUS_MPIE_BIT];
                end
                if (w_wr_mepc) begin
                    r_mepc <= w_new & ALIGN_MASK;
                end
                if (w_wr_mcause) begin
                    r_mcause <= w_new;
                end
            end
            if (w_wr_mtvec) begin
                r_mtvec <= w_new & ALIGN_MASK;
                if ((w_new & ALIGN_MASK) != 32'h0000_0000) begin
                    r_mtvec_ready <= 1'b1;
                end
            end
        end
    end

`ifdef CSR_MCYCLE_EN
    // Free-running cycle counter; a software write to either half replaces the increment.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_mcycle <= 64'h0;
        end else if (w_commit && (bus.CSR_ADDR == CSR_MCYCLE)) begin
            r_mcycle[31:0] <= w_new;
        end else if (w_commit && (bus.CSR_ADDR == CSR_MCYCLEH)) begin
            r_mcycle[63:32] <= w_new;
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end
`endif

    assign bus.CSR_RD      = w_old;
    assign bus.INTR        = w_pending;
    assign bus.MIE         = r_mie;
    assign bus.MTVEC_READY = r_mtvec_ready;
    assign bus.MTVEC       = r_mtvec;
    assign bus.MEPC        = r_mepc;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: table of CSR accesses plus hand-written
// interrupt, reset-during-sync and mcycle sequences.
module tb_csr_unit;
    logic CLK;
    logic RESET_N;
    int   errors = 0;
    int   checks = 0;

    csr_unit_if bus_if();

    csr_unit dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus_if)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic        we;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [31:0] exp_mtvec;
        logic [31:0] exp_mepc;
        logic        exp_mie;
        logic        exp_rdy;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_bus();
        bus_if.CSR_OP    = 2'b00;
        bus_if.CSR_WE    = 1'b0;
        bus_if.CSR_WD    = 32'h0;
        bus_if.TAKE_INTR = 1'b0;
        bus_if.DO_MRET   = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [31:0] data);
        bus_if.CSR_ADDR = addr;
        #1;
        data = bus_if.CSR_RD;
    endtask

    task automatic csr_write(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        bus_if.CSR_OP   = op;
        bus_if.CSR_ADDR = addr;
        bus_if.CSR_WD   = wd;
        bus_if.CSR_WE   = 1'b1;
        tick();
        idle_bus();
    endtask

    logic [31:0] rd;

    initial begin
        vecs[0]  = '{2'd1, 12'h305, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1]  = '{2'd1, 12'h305, 1'b1, 32'h0000_0101, 32'h0000_0000, 32'h0000_0100, 32'h0000_0000, 1'b0, 1'b1};
        vecs[2]  = '{2'd2, 12'h300, 1'b1, 32'h0000_0008, 32'h0000_0000, 32'h0000_0100, 32'h0000_0000, 1'b1, 1'b1};
        vecs[3]  = '{2'd3, 12'h300, 1'b1, 32'h0000_0008, 32'h0000_0008, 32'h0000_0100, 32'h0000_0000, 1'b0, 1'b1};
        vecs[4]  = '{2'd1, 12'h341, 1'b1, 32'h0000_0123, 32'h0000_0000, 32'h0000_0100, 32'h0000_0120, 1'b0, 1'b1};
        vecs[5]  = '{2'd2, 12'h341, 1'b1, 32'h0000_0003, 32'h0000_0120, 32'h0000_0100, 32'h0000_0120, 1'b0, 1'b1};
        vecs[6]  = '{2'd1, 12'h7C0, 1'b1, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_0100, 32'h0000_0120, 1'b0, 1'b1};
        vecs[7]  = '{2'd0, 12'h305, 1'b1, 32'h0000_0000, 32'h0000_0100, 32'h0000_0100, 32'h0000_0120, 1'b0, 1'b1};
        vecs[8]  = '{2'd1, 12'h305, 1'b0, 32'h0000_0000, 32'h0000_0100, 32'h0000_0100, 32'h0000_0120, 1'b0, 1'b1};
        vecs[9]  = '{2'd1, 12'h342, 1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0100, 32'h0000_0120, 1'b0, 1'b1};
        vecs[10] = '{2'd3, 12'h342, 1'b1, 32'h0000_0004, 32'h0000_0005, 32'h0000_0100, 32'h0000_0120, 1'b0, 1'b1};
        vecs[11] = '{2'd0, 12'h342, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'h0000_0100, 32'h0000_0120, 1'b0, 1'b1};
        vecs[12] = '{2'd1, 12'h305, 1'b1, 32'h0000_0000, 32'h0000_0100, 32'h0000_0000, 32'h0000_0120, 1'b0, 1'b1};
        vecs[13] = '{2'd1, 12'h305, 1'b1, 32'h0000_0040, 32'h0000_0000, 32'h0000_0040, 32'h0000_0120, 1'b0, 1'b1};

        RESET_N          = 1'b0;
        bus_if.CSR_ADDR  = 12'h000;
        bus_if.PC        = 32'h0;
        bus_if.INTR_IN   = 1'b0;
        idle_bus();
        repeat (3) tick();
        chk("reset_intr",  {31'd0, bus_if.INTR}, 32'd0);
        chk("reset_mie",   {31'd0, bus_if.MIE}, 32'd0);
        RESET_N = 1'b1;
        tick();
        chk("rel_mtvec", bus_if.MTVEC, 32'h0);
        chk("rel_mepc",  bus_if.MEPC, 32'h0);
        chk("rel_rdy",   {31'd0, bus_if.MTVEC_READY}, 32'd0);

        // Table: read data checked mid-cycle, state checked after the edge.
        for (int i = 0; i < 14; i++) begin
            bus_if.CSR_OP   = vecs[i].op;
            bus_if.CSR_ADDR = vecs[i].addr;
            bus_if.CSR_WE   = vecs[i].we;
            bus_if.CSR_WD   = vecs[i].wd;
            #2;
            chk($sformatf("v%0d_rd", i), bus_if.CSR_RD, vecs[i].exp_rd);
            tick();
            idle_bus();
            chk($sformatf("v%0d_mtvec", i), bus_if.MTVEC, vecs[i].exp_mtvec);
            chk($sformatf("v%0d_mepc", i), bus_if.MEPC, vecs[i].exp_mepc);
            chk($sformatf("v%0d_mie", i), {31'd0, bus_if.MIE}, {31'd0, vecs[i].exp_mie});
            chk($sformatf("v%0d_rdy", i), {31'd0, bus_if.MTVEC_READY}, {31'd0, vecs[i].exp_rdy});
        end

        // Interrupt arrival, trap entry (mstatus write loses) and mret.
        csr_write(2'd2, 12'h300, 32'h8);
        chk("en_mie", {31'd0, bus_if.MIE}, 32'd1);
        bus_if.INTR_IN = 1'b1;
        tick();
        tick();
        chk("intr_e2", {31'd0, bus_if.INTR}, 32'd0);
        tick();
        chk("intr_e3", {31'd0, bus_if.INTR}, 32'd1);
        repeat (7) tick();
        chk("intr_hold", {31'd0, bus_if.INTR}, 32'd1);
        bus_if.INTR_IN   = 1'b0;
        bus_if.TAKE_INTR = 1'b1;
        bus_if.PC        = 32'h0000_0040;
        csr_write(2'd1, 12'h300, 32'h8);
        chk("trap_mepc", bus_if.MEPC, 32'h0000_0040);
        chk("trap_mie",  {31'd0, bus_if.MIE}, 32'd0);
        chk("trap_intr", {31'd0, bus_if.INTR}, 32'd0);
        csr_read(12'h342, rd);
        chk("trap_mcause", rd, 32'h8000_000B);
        csr_read(12'h300, rd);
        chk("trap_mstatus", rd, 32'h0000_0080);
        tick();
        bus_if.DO_MRET = 1'b1;
        tick();
        idle_bus();
        chk("mret_mie", {31'd0, bus_if.MIE}, 32'd1);
        csr_read(12'h300, rd);
        chk("mret_mstatus", rd, 32'h0000_0088);

        // New edge lands on the same edge as TAKE_INTR; mtvec write still commits.
        tick();
        bus_if.INTR_IN = 1'b1;
        tick();
        tick();
        bus_if.TAKE_INTR = 1'b1;
        bus_if.PC        = 32'h0000_008B;
        csr_write(2'd1, 12'h305, 32'h0000_0206);
        chk("coin_intr",  {31'd0, bus_if.INTR}, 32'd1);
        chk("coin_mepc",  bus_if.MEPC, 32'h0000_0088);
        chk("coin_mtvec", bus_if.MTVEC, 32'h0000_0204);
        chk("coin_mie",   {31'd0, bus_if.MIE}, 32'd0);
        bus_if.TAKE_INTR = 1'b1;
        tick();
        idle_bus();
        chk("held_clr", {31'd0, bus_if.INTR}, 32'd0);
        repeat (3) tick();
        chk("held_norearm", {31'd0, bus_if.INTR}, 32'd0);
        bus_if.INTR_IN = 1'b0;

        // Reset mid-synchronization discards the edge.
        repeat (3) tick();
        bus_if.INTR_IN = 1'b1;
        tick();
        RESET_N        = 1'b0;
        bus_if.INTR_IN = 1'b0;
        csr_read(12'h305, rd);
        chk("rst_rd",    rd, 32'h0);
        chk("rst_mtvec", bus_if.MTVEC, 32'h0);
        chk("rst_mepc",  bus_if.MEPC, 32'h0);
        chk("rst_rdy",   {31'd0, bus_if.MTVEC_READY}, 32'd0);
        chk("rst_mie",   {31'd0, bus_if.MIE}, 32'd0);
        tick();
        RESET_N = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("post_rst_intr%0d", c), {31'd0, bus_if.INTR}, 32'd0);
        end

        // mcycle low-half write carries into the high half one cycle later.
        csr_write(2'd1, 12'hB00, 32'hFFFF_FFFF);
`ifdef CSR_MCYCLE_EN
        csr_read(12'hB00, rd);
        chk("mcyc_lo_w", rd, 32'hFFFF_FFFF);
        tick();
        csr_read(12'hB80, rd);
        chk("mcyc_hi", rd, 32'h0000_0001);
        csr_read(12'hB00, rd);
        chk("mcyc_lo_wrap", rd, 32'h0000_0000);
`else
        tick();
        csr_read(12'hB80, rd);
        chk("nomcyc_hi", rd, 32'h0);
        csr_read(12'hB00, rd);
        chk("nomcyc_lo", rd, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
